// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
//   Bundles the board-facing and domain-facing signals of reset_sequencer.
//   The clock and the synchronous reset are plain ports on the sequencer.
//
//   btn_n           raw reset button, active low, asynchronous
//   pll_lock        PLL lock flags, asynchronous, all must be high
//   pll_clk_en      gated-clock enable to PLL enclk, 1 = clock running
//   domain_reset    per-domain reset, active high, released in index order
//   sys_ready       1 = every domain released (RUN)
//   lock_lost_count saturating count of lock losses after clock enable
//   state           FSM state for debug: HOLD=0 WAIT_LOCK=1 CLK_EN=2
//                   RELEASE=3 RUN=4
//
//   master : the sequencer side (drives the enables and resets)
//   slave  : the board side (drives the button and lock flags)
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
   parameter int NUM_LOCKS   = 1,
   parameter int NUM_DOMAINS = 3
);
   logic                   btn_n;
   logic [NUM_LOCKS-1:0]   pll_lock;
   logic                   pll_clk_en;
   logic [NUM_DOMAINS-1:0] domain_reset;
   logic                   sys_ready;
   logic [7:0]             lock_lost_count;
   logic [2:0]             state;

   modport master (
      input  btn_n,
      input  pll_lock,
      output pll_clk_en,
      output domain_reset,
      output sys_ready,
      output lock_lost_count,
      output state
   );

   modport slave (
      output btn_n,
      output pll_lock,
      input  pll_clk_en,
      input  domain_reset,
      input  sys_ready,
      input  lock_lost_count,
      input  state
   );
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Clock/reset sequencer for the FPGA top level. Debounces the board reset
//   button, qualifies the PLL lock flags, then enables the gated memory clock
//   and releases the domain resets one at a time. A lock loss or a button
//   press after the clock is enabled drops everything back into HOLD, giving
//   a controlled restart of all downstream domains.
//
//   Ports
//     io_axiClk  in  system clock, every register on its rising edge
//     io_reset   in  synchronous active-high reset
//     bus        reset_sequencer_if.master (button, locks, enables, resets,
//                ready flag, lock-loss counter, debug state)
//
//   Parameters (all expected to be >= 1)
//     NUM_LOCKS          number of PLL lock inputs, all must be high
//     NUM_DOMAINS        number of domain resets, released in index order
//     DEBOUNCE_CYCLES    consecutive differing samples before the button flips
//     HOLD_CYCLES        minimum cycles spent in HOLD per entry
//     LOCK_STABLE_CYCLES consecutive all-locked cycles before clock enable
//     STAGE_DELAY_CYCLES cycles between clock enable and each reset release
// -----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int NUM_LOCKS          = 1,
   parameter int NUM_DOMAINS        = 3,
   parameter int DEBOUNCE_CYCLES    = 65536,
   parameter int HOLD_CYCLES        = 256,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_DELAY_CYCLES = 64
) (
   input  logic               io_axiClk,
   input  logic               io_reset,
   reset_sequencer_if.master  bus
);

   // Counter widths hold the full parameter value, so no count ever truncates.
   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
   localparam int LOCK_W  = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int STAGE_W = $clog2(STAGE_DELAY_CYCLES + 1);

   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_MIN   = HOLD_W'(HOLD_CYCLES);
   localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY_CYCLES - 1);

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      CLK_EN    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_t;

   // Two-flop synchronisers for the asynchronous board inputs.
   logic                   btn_meta;
   logic                   btn_sync;
   logic [NUM_LOCKS-1:0]   lock_meta;
   logic [NUM_LOCKS-1:0]   lock_sync;

   // Debounced button level: 1 = released, 0 = pressed.
   logic                   btn_level;
   logic [DEB_W-1:0]       deb_cnt;

   logic [HOLD_W-1:0]      hold_cnt;
   logic [LOCK_W-1:0]      lock_cnt;
   logic [STAGE_W-1:0]     stage_cnt;

   state_t                 state_q;
   logic                   pll_clk_en_q;
   logic [NUM_DOMAINS-1:0] domain_reset_q;
   logic                   sys_ready_q;
   logic [7:0]             lost_cnt_q;

   logic                   lock_all;
   logic                   pressed;
   logic                   in_seq;
   logic                   abort_now;
   logic [NUM_DOMAINS-1:0] dr_next;

   assign lock_all  = &lock_sync;
   assign pressed   = ~btn_level;

   // Once the gated clock is running, any lock loss or press restarts.
   assign in_seq    = (state_q == CLK_EN) || (state_q == RELEASE) || (state_q == RUN);
   assign abort_now = in_seq && (!lock_all || pressed);

   // Releasing domains in index order is a left shift that feeds in zeros:
   // 111 -> 110 -> 100 -> 000. All-zero after the shift means the last
   // domain is being released, which is also the single-domain case.
   assign dr_next   = domain_reset_q << 1;

   // NOTE: every register here is assigned with <= so all of them update
   // from the same pre-edge values; blocking assignments would let later
   // statements see half-updated state and break the two-flop synchronisers.
   always_ff @(posedge io_axiClk) begin
      if (io_reset) begin
         btn_meta       <= 1'b1;
         btn_sync       <= 1'b1;
         btn_level      <= 1'b1;
         deb_cnt        <= '0;
         lock_meta      <= '0;
         lock_sync      <= '0;
         hold_cnt       <= '0;
         lock_cnt       <= '0;
         stage_cnt      <= '0;
         state_q        <= HOLD;
         pll_clk_en_q   <= 1'b0;
         domain_reset_q <= '1;
         sys_ready_q    <= 1'b0;
         lost_cnt_q     <= '0;
      end else begin
         btn_meta  <= bus.btn_n;
         btn_sync  <= btn_meta;
         lock_meta <= bus.pll_lock;
         lock_sync <= lock_meta;

         // Debounce: a run of differing samples flips the level on its last
         // sample; any sample matching the current level restarts the run.
         if (btn_sync == btn_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            btn_level <= btn_sync;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end

         if (abort_now) begin
            state_q        <= HOLD;
            pll_clk_en_q   <= 1'b0;
            domain_reset_q <= '1;
            sys_ready_q    <= 1'b0;
            stage_cnt      <= '0;
            hold_cnt       <= '0;
            lock_cnt       <= '0;
            // Lock loss wins over a simultaneous press for the counter.
            if (!lock_all && lost_cnt_q != 8'hFF)
               lost_cnt_q <= lost_cnt_q + 8'd1;
         end else begin
            unique case (state_q)
               HOLD: begin
                  lock_cnt  <= '0;
                  stage_cnt <= '0;
                  if (hold_cnt >= HOLD_MIN && !pressed) begin
                     state_q  <= WAIT_LOCK;
                     hold_cnt <= '0;
                  end else if (hold_cnt < HOLD_MIN) begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end

               WAIT_LOCK: begin
                  if (pressed) begin
                     state_q  <= HOLD;
                     hold_cnt <= '0;
                     lock_cnt <= '0;
                  end else if (!lock_all) begin
                     lock_cnt <= '0;
                  end else if (lock_cnt == LOCK_LAST) begin
                     state_q      <= CLK_EN;
                     pll_clk_en_q <= 1'b1;
                     lock_cnt     <= '0;
                     stage_cnt    <= '0;
                  end else begin
                     lock_cnt <= lock_cnt + LOCK_W'(1);
                  end
               end

               CLK_EN, RELEASE: begin
                  if (stage_cnt == STAGE_LAST) begin
                     stage_cnt      <= '0;
                     domain_reset_q <= dr_next;
                     if (dr_next == '0) begin
                        state_q     <= RUN;
                        sys_ready_q <= 1'b1;
                     end else begin
                        state_q <= RELEASE;
                     end
                  end else begin
                     stage_cnt <= stage_cnt + STAGE_W'(1);
                  end
               end

               RUN: begin
                  stage_cnt <= '0;
               end

               default: begin
                  // Unused encodings recover through a clean HOLD entry.
                  state_q        <= HOLD;
                  pll_clk_en_q   <= 1'b0;
                  domain_reset_q <= '1;
                  sys_ready_q    <= 1'b0;
                  hold_cnt       <= '0;
                  lock_cnt       <= '0;
                  stage_cnt      <= '0;
               end
            endcase
         end
      end
   end

   assign bus.pll_clk_en      = pll_clk_en_q;
   assign bus.domain_reset    = domain_reset_q;
   assign bus.sys_ready       = sys_ready_q;
   assign bus.lock_lost_count = lost_cnt_q;
   assign bus.state           = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench for reset_sequencer with NUM_LOCKS=2 NUM_DOMAINS=3
//   DEBOUNCE=4 HOLD=6 LOCK_STABLE=8 STAGE=5. Each step pushes the output
//   changes it expects (cycle offset from a reference edge plus the full
//   output vector) onto a queue; collect() pops them as the outputs change.
//   Output vector = {state, pll_clk_en, domain_reset, sys_ready, count}.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

   localparam int NL    = 2;
   localparam int ND    = 3;
   localparam int DEB   = 4;
   localparam int HOLD  = 6;
   localparam int LOCK  = 8;
   localparam int STAGE = 5;

   logic clk = 1'b0;
   logic io_reset;

   reset_sequencer_if #(.NUM_LOCKS(NL), .NUM_DOMAINS(ND)) bus_if ();

   reset_sequencer #(
      .NUM_LOCKS         (NL),
      .NUM_DOMAINS       (ND),
      .DEBOUNCE_CYCLES   (DEB),
      .HOLD_CYCLES       (HOLD),
      .LOCK_STABLE_CYCLES(LOCK),
      .STAGE_DELAY_CYCLES(STAGE)
   ) dut (
      .io_axiClk(clk),
      .io_reset (io_reset),
      .bus      (bus_if)
   );

   always #5 clk = ~clk;

   // Number of rising edges so far; read on falling edges only.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [15:0] obs_vec;
   assign obs_vec = {bus_if.state, bus_if.pll_clk_en, bus_if.domain_reset,
                     bus_if.sys_ready, bus_if.lock_lost_count};

   typedef struct {
      string       tag;
      int          dcyc;
      logic [15:0] vec;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [15:0] M_STATE = 16'hE000;
   localparam logic [15:0] M_EN    = 16'h1000;
   localparam logic [15:0] M_DR    = 16'h0E00;

   function automatic logic [15:0] pack(input logic [2:0] st, input logic en,
                                        input logic [2:0] dr, input logic rdy,
                                        input logic [7:0] cnt);
      return {st, en, dr, rdy, cnt};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic push(input string tag, input int dcyc, input logic [2:0] st,
                       input logic en, input logic [2:0] dr, input logic rdy,
                       input logic [7:0] cnt);
      exp_t e;
      e.tag  = tag;
      e.dcyc = dcyc;
      e.vec  = pack(st, en, dr, rdy, cnt);
      exp_q.push_back(e);
   endtask

   // Pops every queued expectation in order; each one must match the next
   // change of the output vector, both in value and in cycle offset.
   task automatic collect(input int ref_cyc, input int budget);
      logic [15:0] last;
      exp_t        e;
      int          waited;
      last = obs_vec;
      while (exp_q.size() > 0) begin
         e      = exp_q.pop_front();
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (obs_vec === last && waited < budget);
         if (obs_vec === last) begin
            checks++;
            errors++;
            $error("FAIL %s: no output change within %0d cycles, observed %0h expected %0h",
                   e.tag, budget, obs_vec, e.vec);
         end else begin
            check({e.tag, ".cyc"}, cyc - ref_cyc, e.dcyc);
            check({e.tag, ".out"}, obs_vec, e.vec);
            last = obs_vec;
         end
      end
   endtask

   // Outputs must hold the given vector on every falling edge up to abs_cyc.
   task automatic quiet_until(input string tag, input int abs_cyc, input logic [15:0] want);
      while (cyc < abs_cyc && obs_vec === want) @(negedge clk);
      check(tag, obs_vec, want);
   endtask

   task automatic wait_until(input string tag, input logic [15:0] mask,
                             input logic [15:0] val, input int budget);
      int waited = 0;
      while ((obs_vec & mask) !== val && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      if ((obs_vec & mask) !== val) begin
         checks++;
         errors++;
         $error("FAIL %s: observed %0h expected %0h under mask %0h",
                tag, obs_vec & mask, val, mask);
      end
   endtask

   // Reset release at reference r, locks and button already good.
   task automatic push_full(input string tag, input int base, input logic [7:0] cnt);
      push({tag, ".wait"},  base,      3'd1, 1'b0, 3'b111, 1'b0, cnt);
      push({tag, ".clken"}, base + 8,  3'd2, 1'b1, 3'b111, 1'b0, cnt);
      push({tag, ".dr0"},   base + 13, 3'd3, 1'b1, 3'b110, 1'b0, cnt);
      push({tag, ".dr1"},   base + 18, 3'd3, 1'b1, 3'b100, 1'b0, cnt);
      push({tag, ".run"},   base + 23, 3'd4, 1'b1, 3'b000, 1'b1, cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int m;
      int p;
      int a;

      // 1. reset, then locks and button good: full sequence
      io_reset        = 1'b1;
      bus_if.btn_n    = 1'b1;
      bus_if.pll_lock = 2'b11;
      repeat (3) @(negedge clk);
      check("s1.reset", obs_vec, pack(3'd0, 1'b0, 3'b111, 1'b0, 8'd0));
      io_reset = 1'b0;
      r = cyc;
      push_full("s1", 7, 8'd0);
      collect(r, 40);

      // 2. lock drop in WAIT_LOCK at count 6 restarts the stability count
      io_reset = 1'b1;
      @(negedge clk);
      check("s2.reset", obs_vec, pack(3'd0, 1'b0, 3'b111, 1'b0, 8'd0));
      io_reset = 1'b0;
      r = cyc;
      push("s2.wait", 7, 3'd1, 1'b0, 3'b111, 1'b0, 8'd0);
      collect(r, 20);
      quiet_until("s2.counting", r + 11, pack(3'd1, 1'b0, 3'b111, 1'b0, 8'd0));
      bus_if.pll_lock = 2'b01;
      @(negedge clk);
      bus_if.pll_lock = 2'b11;
      push("s2.clken", 22, 3'd2, 1'b1, 3'b111, 1'b0, 8'd0);
      push("s2.dr0",   27, 3'd3, 1'b1, 3'b110, 1'b0, 8'd0);
      push("s2.dr1",   32, 3'd3, 1'b1, 3'b100, 1'b0, 8'd0);
      push("s2.run",   37, 3'd4, 1'b1, 3'b000, 1'b1, 8'd0);
      collect(r, 40);

      // 3. lock loss in RUN aborts and counts, then the sequence repeats
      m = cyc;
      bus_if.pll_lock = 2'b01;
      push("s3.abort", 3, 3'd0, 1'b0, 3'b111, 1'b0, 8'd1);
      collect(m, 10);
      bus_if.pll_lock = 2'b11;
      push_full("s3", 10, 8'd1);
      collect(m, 40);

      // 4. a 3-cycle glitch is ignored; a long press aborts without counting
      m = cyc;
      bus_if.btn_n = 1'b0;
      quiet_until("s4.glitch_low", m + 3, pack(3'd4, 1'b1, 3'b000, 1'b1, 8'd1));
      bus_if.btn_n = 1'b1;
      quiet_until("s4.glitch_after", m + 20, pack(3'd4, 1'b1, 3'b000, 1'b1, 8'd1));
      p = cyc;
      bus_if.btn_n = 1'b0;
      push("s4.press", 7, 3'd0, 1'b0, 3'b111, 1'b0, 8'd1);
      collect(p, 20);
      quiet_until("s4.held", p + 20, pack(3'd0, 1'b0, 3'b111, 1'b0, 8'd1));
      bus_if.btn_n = 1'b1;
      push_full("s4", 27, 8'd1);
      collect(p, 40);

      // 5. 256 more lock-loss aborts: counter saturates at 255
      for (int i = 0; i < 256; i++) begin
         wait_until($sformatf("s5.en%0d", i), M_EN, M_EN, 40);
         a = cyc;
         bus_if.pll_lock = 2'b01;
         push($sformatf("s5.abort%0d", i), 3, 3'd0, 1'b0, 3'b111, 1'b0,
              (i + 2 > 255) ? 8'd255 : 8'(i + 2));
         collect(a, 10);
         bus_if.pll_lock = 2'b11;
      end
      check("s5.saturated", {24'd0, bus_if.lock_lost_count}, 32'd255);

      // 6. io_reset in RELEASE with domain_reset=100 wins on the next edge
      wait_until("s6.dr100", M_DR | M_STATE, pack(3'd3, 1'b0, 3'b100, 1'b0, 8'd0) & (M_DR | M_STATE), 40);
      m = cyc;
      io_reset = 1'b1;
      push("s6.reset", 1, 3'd0, 1'b0, 3'b111, 1'b0, 8'd0);
      collect(m, 5);
      io_reset = 1'b0;
      r = cyc;
      push_full("s6", 7, 8'd0);
      collect(r, 40);

      // 7. lock loss and debounced press on the same cycle count once
      p = cyc;
      bus_if.btn_n = 1'b0;
      quiet_until("s7.pre", p + 4, pack(3'd4, 1'b1, 3'b000, 1'b1, 8'd0));
      bus_if.pll_lock = 2'b01;
      push("s7.both", 7, 3'd0, 1'b0, 3'b111, 1'b0, 8'd1);
      collect(p, 10);
      bus_if.btn_n    = 1'b1;
      bus_if.pll_lock = 2'b11;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
